// File: rtl/lenet_approx_pkg.sv
// Shared constants and helpers for the approximate dot-product MAC.
// The compensation constant is half the weight of the lowest kept column.
package lenet_approx_pkg;

  localparam int DEF_W     = 8;
  localparam int DEF_ACC_W = 24;

  function automatic int unsigned comp_const(input int unsigned trunc);
    return (trunc == 0) ? 32'd0 : (32'd1 << (trunc - 1));
  endfunction

endpackage

// File: rtl/lenet_approx_mac_if.sv
// Operand-beat and result channels of the approximate MAC, valid/ready on both.
// The master modport is the producer/consumer side; the slave modport is the MAC.
interface lenet_approx_mac_if
  import lenet_approx_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int ACC_W = DEF_ACC_W
);
  localparam int TW = $clog2(2*W);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_x;
  logic [W-1:0]     in_y;
  logic             in_last;
  logic [TW-1:0]    cfg_trunc;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_sat;

  modport master (
    output in_valid, in_x, in_y, in_last, cfg_trunc, out_ready,
    input  in_ready, out_valid, out_acc, out_sat
  );

  modport slave (
    input  in_valid, in_x, in_y, in_last, cfg_trunc, out_ready,
    output in_ready, out_valid, out_acc, out_sat
  );

endinterface

// File: rtl/lenet_trunc_mul.sv
// Column-truncated unsigned W x W multiplier; LENET_APPROX_MAC_ERR_COMP_EN adds 2^(trunc-1).
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module lenet_trunc_mul
  import lenet_approx_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0]          x,
  input  logic [W-1:0]          y,
  input  logic [$clog2(2*W)-1:0] trunc,
  output logic [2*W:0]          prod
);
  // One spare bit so the compensation term can never wrap the product.
  localparam int PW = 2*W + 1;

  always_comb begin
    prod = '0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        if (x[i] && y[j] && ((i + j) >= int'(trunc))) begin
          prod = prod + (PW'(1) << (i + j));
        end
      end
    end
`ifdef LENET_APPROX_MAC_ERR_COMP_EN
    if (trunc != '0) begin
      prod = prod + PW'(comp_const(32'(trunc)));
    end
`endif
  end

endmodule

// File: rtl/lenet_approx_mac.sv
// Approximate dot-product MAC: S1 operands, S2 truncated product, S3 accumulate with clamp.
// Latency: result valid on the 3rd rising edge after the last beat's handshake.
// Backpressure: a held result stalls every stage; in_ready equals the stage-advance enable.
module lenet_approx_mac
  import lenet_approx_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input logic               clk,
  input logic               rst_n,
  lenet_approx_mac_if.slave bus
);
  localparam int TW = $clog2(2*W);
  localparam int PW = 2*W + 1;
  localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;

  logic             advance;
  logic             s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
  logic [W-1:0]     s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic [TW-1:0]    s1_trunc_q, s1_trunc_d;
  logic             s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
  logic [PW-1:0]    s2_prod_q, s2_prod_d;
  logic             s3_vld_q, s3_vld_d, s3_last_q, s3_last_d;
  logic [PW-1:0]    s3_prod_q, s3_prod_d;
  logic [ACC_W-1:0] acc_q, acc_d, out_acc_q, out_acc_d;
  logic             sat_q, sat_d, out_vld_q, out_vld_d, out_sat_q, out_sat_d;
  logic [PW-1:0]    mul_prod;
  logic [SW-1:0]    sum;
  logic             ovf;
  logic [ACC_W-1:0] acc_clamped;

  lenet_trunc_mul #(.W(W)) u_mul (
    .x     (s1_x_q),
    .y     (s1_y_q),
    .trunc (s1_trunc_q),
    .prod  (mul_prod)
  );

  assign advance     = !(out_vld_q && !bus.out_ready);
  assign sum         = SW'(acc_q) + SW'(s3_prod_q);
  assign ovf         = sum > SW'({ACC_W{1'b1}});
  assign acc_clamped = ovf ? '1 : sum[ACC_W-1:0];

  assign bus.in_ready  = advance;
  assign bus.out_valid = out_vld_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_sat   = out_sat_q;

  always_comb begin
    s1_vld_d   = s1_vld_q;
    s1_last_d  = s1_last_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    s1_trunc_d = s1_trunc_q;
    s2_vld_d   = s2_vld_q;
    s2_last_d  = s2_last_q;
    s2_prod_d  = s2_prod_q;
    s3_vld_d   = s3_vld_q;
    s3_last_d  = s3_last_q;
    s3_prod_d  = s3_prod_q;
    acc_d      = acc_q;
    sat_d      = sat_q;
    out_vld_d  = out_vld_q;
    out_acc_d  = out_acc_q;
    out_sat_d  = out_sat_q;
    if (advance) begin
      s1_vld_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_last_d  = bus.in_last;
        s1_x_d     = bus.in_x;
        s1_y_d     = bus.in_y;
        s1_trunc_d = bus.cfg_trunc;
      end
      s2_vld_d  = s1_vld_q;
      s2_last_d = s1_last_q;
      s2_prod_d = mul_prod;
      s3_vld_d  = s2_vld_q;
      s3_last_d = s2_last_q;
      s3_prod_d = s2_prod_q;
      // Advancing means any held result is being taken this cycle.
      out_vld_d = 1'b0;
      if (s3_vld_q) begin
        if (s3_last_q) begin
          out_vld_d = 1'b1;
          out_acc_d = acc_clamped;
          out_sat_d = sat_q | ovf;
          acc_d     = '0;
          sat_d     = 1'b0;
        end else begin
          acc_d = acc_clamped;
          sat_d = sat_q | ovf;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_trunc_q <= '0;
      s2_vld_q   <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_prod_q  <= '0;
      s3_vld_q   <= 1'b0;
      s3_last_q  <= 1'b0;
      s3_prod_q  <= '0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      out_vld_q  <= 1'b0;
      out_acc_q  <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_last_q  <= s1_last_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_trunc_q <= s1_trunc_d;
      s2_vld_q   <= s2_vld_d;
      s2_last_q  <= s2_last_d;
      s2_prod_q  <= s2_prod_d;
      s3_vld_q   <= s3_vld_d;
      s3_last_q  <= s3_last_d;
      s3_prod_q  <= s3_prod_d;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      out_vld_q  <= out_vld_d;
      out_acc_q  <= out_acc_d;
      out_sat_q  <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_lenet_approx_mac.sv
// Bench for lenet_approx_mac (W=8, ACC_W=16): table vectors, directed stall/reset
// sequences and random dot products against a transaction-level model.
module tb_lenet_approx_mac;

  localparam int W     = 8;
  localparam int ACC_W = 16;
  localparam longint MAXV = (64'd1 << ACC_W) - 1;

  typedef struct {
    longint acc;
    bit     sat;
  } res_t;

  typedef struct {
    int unsigned x0, y0, x1, y1;
    int          nb;
    int unsigned t;
    longint      acc;
    bit          sat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lenet_approx_mac_if #(.W(W), .ACC_W(ACC_W)) bus ();

  lenet_approx_mac #(.W(W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int     n_vec = 0;
  int     n_err = 0;
  int     or_mode = 0;   // 0: always ready, 1: random, 2: held low
  res_t   exp_q[$];
  longint m_acc = 0;
  bit     m_sat = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Truncated product as the exact product minus the dropped low-column part of each row.
  function automatic longint model_prod(input int unsigned x, y, t);
    longint p;
    p = longint'(x) * longint'(y);
    for (int i = 0; i < W; i++) begin
      if (i < int'(t) && ((x >> i) & 1) == 1)
        p -= (longint'(1) << i) * longint'(y % (32'd1 << (t - i)));
    end
`ifdef LENET_APPROX_MAC_ERR_COMP_EN
    if (t > 0) p += longint'(1) << (t - 1);
`endif
    return p;
  endfunction

  task automatic send_beat(input int unsigned x, y, t, input bit last, input bit use_model);
    bit     took;
    int     cyc;
    longint s;
    took = 1'b0;
    cyc  = 0;
    bus.in_valid  = 1'b1;
    bus.in_x      = x[W-1:0];
    bus.in_y      = y[W-1:0];
    bus.cfg_trunc = t[3:0];
    bus.in_last   = last;
    while (!took && cyc < 200) begin
      @(negedge clk);
      took = bus.in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    if (!took) begin
      n_vec++;
      n_err++;
      $display("FAIL beat_accept: in_ready never seen, required within 200 cycles");
    end else if (use_model) begin
      s = m_acc + model_prod(x, y, t);
      if (s > MAXV) begin
        m_acc = MAXV;
        m_sat = 1'b1;
      end else begin
        m_acc = s;
      end
      if (last) begin
        exp_q.push_back('{acc: m_acc, sat: m_sat});
        m_acc = 0;
        m_sat = 1'b0;
      end
    end
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && c < 300) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("drain_timeout", (c >= 300), 0);
  endtask

  task automatic run_random(input int ndots, input bit bubbles);
    int          len;
    int unsigned t;
    for (int d = 0; d < ndots; d++) begin
      len = $urandom_range(1, 4);
      t   = ($urandom % 4 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      for (int b = 0; b < len; b++) begin
        if (bubbles && ($urandom % 3 == 0)) begin
          repeat ($urandom_range(1, 3)) begin
            @(posedge clk);
            #1;
          end
        end
        send_beat($urandom_range(0, 255), $urandom_range(0, 255), t, (b == len - 1), 1'b1);
      end
    end
  endtask

  // Results are scored at the transfer moment, in order, against the expected queue.
  always @(negedge clk) begin : monitor
    res_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got acc %0d, expected no result", bus.out_acc);
      end else begin
        e = exp_q.pop_front();
        check("result_acc", bus.out_acc, e.acc);
        check("result_sat", bus.out_sat, e.sat);
      end
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom % 4) != 0;
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    int   lat;
    int   c;

    tbl[0] = '{255, 255, 0, 0, 1, 0, 65025, 1'b0};
`ifdef LENET_APPROX_MAC_ERR_COMP_EN
    tbl[1] = '{15, 15, 0, 0, 1, 4, 184, 1'b0};
    tbl[4] = '{3, 3, 0, 0, 1, 1, 9, 1'b0};
    tbl[5] = '{255, 255, 0, 0, 1, 14, 24576, 1'b0};
    tbl[8] = '{255, 255, 0, 0, 1, 15, 16384, 1'b0};
`else
    tbl[1] = '{15, 15, 0, 0, 1, 4, 176, 1'b0};
    tbl[4] = '{3, 3, 0, 0, 1, 1, 8, 1'b0};
    tbl[5] = '{255, 255, 0, 0, 1, 14, 16384, 1'b0};
    tbl[8] = '{255, 255, 0, 0, 1, 15, 0, 1'b0};
`endif
    tbl[2] = '{255, 255, 255, 255, 2, 0, 65535, 1'b1};
    tbl[3] = '{2, 3, 0, 0, 1, 0, 6, 1'b0};
    tbl[6] = '{100, 7, 3, 5, 2, 0, 715, 1'b0};
    tbl[7] = '{0, 200, 0, 0, 1, 0, 0, 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_last   = 1'b0;
    bus.cfg_trunc = '0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_acc", bus.out_acc, 0);
    check("rst_out_sat", bus.out_sat, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready", bus.in_ready, 1);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].nb == 2) send_beat(tbl[i].x0, tbl[i].y0, tbl[i].t, 1'b0, 1'b0);
      if (tbl[i].nb == 2) send_beat(tbl[i].x1, tbl[i].y1, tbl[i].t, 1'b1, 1'b0);
      else                send_beat(tbl[i].x0, tbl[i].y0, tbl[i].t, 1'b1, 1'b0);
      exp_q.push_back('{acc: tbl[i].acc, sat: tbl[i].sat});
      if (i == 0) begin
        lat = 0;
        do begin
          @(posedge clk);
          #1;
          lat++;
        end while (!bus.out_valid && lat < 8);
        check("latency_edges", lat, 3);
      end
      wait_drain();
    end

    // Held result blocks intake; the beat waiting meanwhile must survive.
    or_mode = 2;
    bus.out_ready = 1'b0;
    send_beat(9, 9, 0, 1'b1, 1'b1);
    c = 0;
    while (!bus.out_valid && c < 20) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("stall_result_seen", bus.out_valid, 1);
    bus.in_valid = 1'b1;
    bus.in_x = 8'd4;
    bus.in_y = 8'd5;
    bus.cfg_trunc = '0;
    bus.in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_out_acc", bus.out_acc, 81);
    end
    or_mode = 0;
    bus.out_ready = 1'b1;
    send_beat(4, 5, 0, 1'b1, 1'b1);
    wait_drain();

    // Reset in the middle of a dot product drops the partial sum.
    send_beat(10, 10, 0, 1'b0, 1'b1);
    send_beat(20, 20, 0, 1'b0, 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_acc", bus.out_acc, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_acc = 0;
    m_sat = 1'b0;
    exp_q.delete();
    check("midrst_in_ready", bus.in_ready, 1);
    send_beat(1, 1, 0, 1'b1, 1'b0);
    exp_q.push_back('{acc: 1, sat: 1'b0});
    wait_drain();

    or_mode = 0;
    run_random(30, 1'b0);
    wait_drain();
    or_mode = 1;
    run_random(40, 1'b1);
    wait_drain();
    or_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lenet_approx_mac.md
LENET_APPROX_MAC -- requirements
Module: lenet_approx_mac

Interface
REQ-001 Parameter W, default 8: operand width, power of two, 4..16.
REQ-002 Parameter ACC_W, default 24: accumulator and result width, at least 2*W.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 cfg_trunc  input  $clog2(2*W)  number of low product columns dropped per beat; 0 = exact.
REQ-006 in_valid  input  1  operand beat valid.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_x  input  W  unsigned operand x.
REQ-009 in_y  input  W  unsigned operand y.
REQ-010 in_last  input  1  marks the final beat of a dot product.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_acc  output  ACC_W  dot-product result.
REQ-014 out_sat  output  1  result saturated.

Function
REQ-015 A beat SHALL transfer when in_valid && in_ready; a result SHALL transfer when out_valid && out_ready.
REQ-016 Approximate product SHALL be the sum of partial-product bits x[i]&y[j] weighted 2^(i+j), over all i+j >= cfg_trunc only.
REQ-017 cfg_trunc SHALL be sampled with each accepted beat and travel with that beat's data.
REQ-018 Pipeline SHALL have three stages: S1 operand/flag register, S2 product register, S3 accumulate.
REQ-019 Stage advance = !(out_valid && !out_ready); in_ready SHALL equal advance; when advance is low all stages hold.
REQ-020 S3 SHALL add each valid product to the accumulator; add result exceeding 2^ACC_W-1 SHALL clamp to 2^ACC_W-1 and set a sticky saturation flag.
REQ-021 On a last beat in S3, out_acc SHALL take the final sum, out_sat the final sticky flag, and out_valid SHALL rise.
REQ-022 On a last beat in S3, accumulator and sticky flag SHALL clear in the same cycle.
REQ-023 With no stall, out_valid SHALL assert on the 3rd rising edge after the last beat's handshake edge.
REQ-024 out_acc/out_sat SHALL hold stable while out_valid && !out_ready.
REQ-025 Result handshake and a new input handshake in the same cycle SHALL both complete.
REQ-026 A single-beat dot product (in_last on first beat) SHALL yield that beat's product.
REQ-027 Bubbles (in_valid low) SHALL not alter the accumulator.

Reset
REQ-028 rst_n low SHALL immediately clear all stage valids, accumulator, sticky flag, out_valid=0, out_acc=0, out_sat=0; in_ready=1 after release.
REQ-029 Reset mid-dot-product SHALL discard the partial sum; the next beat starts a new dot product.

Configuration
REQ-030 Macro LENET_APPROX_MAC_ERR_COMP_EN defined: each product with cfg_trunc>0 SHALL add the constant 2^(cfg_trunc-1) as truncation-error compensation.
REQ-031 Macro undefined: no compensation is added; the product is the pure truncated sum.

Structure
REQ-032 Package lenet_approx_pkg SHALL hold default W/ACC_W constants and the compensation-constant function.
REQ-033 Sub-module lenet_trunc_mul (combinational column-truncated W x W multiplier) SHALL implement S2 logic.

Verification
REQ-034 W=8, trunc=0, single beat x=255 y=255 last -> out_acc=65025, out_sat=0, 3 cycles latency.
REQ-035 W=8, trunc=4, single beat x=15 y=15 -> out_acc=176 without macro, 184 with macro.
REQ-036 ACC_W=16, trunc=0, two beats 255x255 then last -> out_acc=65535, out_sat=1; next dot product 2x3 last -> 6, out_sat=0.
REQ-037 out_ready held low 5 cycles with a result pending -> out_acc stable, in_ready=0, no beat lost after release.
REQ-038 rst_n pulsed after 2 of 4 beats, then 1x1 last -> out_acc=1.
REQ-039 Back-to-back dot products, out_ready=1, in_valid=1 continuous -> one result per last beat, no gaps or corruption.
